// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RISC-V funct3 size codes,
// error cause codes and the master FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_ILL   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_if.sv
// Word-wide data-memory bus between the load/store master and its responder.
interface lsu_mem_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store enables/replication, legality
// flags for the incoming request, and extension of the returned load word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic        req_we,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_lane_wdata,
  output logic        req_illegal,
  output logic        req_misaligned,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Loads always read the full word; only stores narrow the enables.
  always_comb begin
    req_be         = 4'b1111;
    req_lane_wdata = req_wdata;
    if (req_we) begin
      case (req_funct3)
        F3_B: begin
          req_be         = 4'b0001 << req_addr_lo;
          req_lane_wdata = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          req_be         = req_addr_lo[1] ? 4'b1100 : 4'b0011;
          req_lane_wdata = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (req_funct3)
      F3_B:         req_illegal = 1'b0;
      F3_H:         req_misaligned = req_addr_lo[0];
      F3_W:         req_misaligned = |req_addr_lo;
      F3_BU:        req_illegal = req_we;
      F3_HU: begin
        req_illegal    = req_we;
        req_misaligned = req_addr_lo[0];
      end
      default:      req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = rsp_rdata[7:0];
    case (rsp_addr_lo)
      2'd0: ld_byte = rsp_rdata[7:0];
      2'd1: ld_byte = rsp_rdata[15:8];
      2'd2: ld_byte = rsp_rdata[23:16];
      2'd3: ld_byte = rsp_rdata[31:24];
      default: ;
    endcase
    ld_half = rsp_addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];

    case (rsp_funct3)
      F3_B:    rsp_load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   rsp_load_data = {24'h000000, ld_byte};
      F3_H:    rsp_load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   rsp_load_data = {16'h0000, ld_half};
      default: rsp_load_data = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one core request, issues a single word
// access on the memory bus and returns a done pulse with extended data.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err,
  output logic [1:0]        err_cause,
  lsu_mem_if.master         mem
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  lsu_state_e        state_reg;
  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        addr_lo_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [3:0]        mem_be_reg;
  logic [31:0]       mem_wdata_reg;
  logic              done_reg;
  logic              err_reg;
  logic [1:0]        err_cause_reg;
  logic [31:0]       load_data_reg;
  logic [31:0]       tmo_cnt_reg;

  logic [3:0]        req_be;
  logic [31:0]       req_lane_wdata;
  logic              req_illegal;
  logic              req_misaligned;
  logic [31:0]       rsp_load_data;

  lsu_align u_align (
    .req_funct3     (cpu_funct3),
    .req_we         (cpu_we),
    .req_addr_lo    (cpu_addr[1:0]),
    .req_wdata      (cpu_wdata),
    .req_be         (req_be),
    .req_lane_wdata (req_lane_wdata),
    .req_illegal    (req_illegal),
    .req_misaligned (req_misaligned),
    .rsp_funct3     (funct3_reg),
    .rsp_addr_lo    (addr_lo_reg),
    .rsp_rdata      (mem.mem_rdata),
    .rsp_load_data  (rsp_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      addr_lo_reg   <= 2'b00;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= 4'b0000;
      mem_wdata_reg <= 32'h0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_cause_reg <= ERR_NONE;
      load_data_reg <= 32'h0;
      tmo_cnt_reg   <= 32'h0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cpu_req) begin
            we_reg        <= cpu_we;
            funct3_reg    <= cpu_funct3;
            addr_lo_reg   <= cpu_addr[1:0];
            mem_addr_reg  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_be_reg    <= req_be;
            mem_wdata_reg <= req_lane_wdata;
            // Rejected requests skip the bus entirely and answer next cycle.
            if (req_illegal || req_misaligned) begin
              state_reg     <= ST_RESP;
              done_reg      <= 1'b1;
              err_reg       <= 1'b1;
              err_cause_reg <= req_illegal ? ERR_ILL : ERR_MISAL;
              load_data_reg <= 32'h0;
            end else begin
              state_reg   <= ST_BUSY;
              mem_req_reg <= 1'b1;
              mem_we_reg  <= cpu_we;
              tmo_cnt_reg <= 32'h0;
            end
          end
        end
        ST_BUSY: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (mem.mem_ack) begin
            state_reg     <= ST_RESP;
            done_reg      <= 1'b1;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            err_cause_reg <= ERR_NONE;
            load_data_reg <= we_reg ? 32'h0 : rsp_load_data;
          end else if (TIMEOUT_CYCLES != 0 && tmo_cnt_reg == TMO_LAST) begin
            state_reg     <= ST_RESP;
            done_reg      <= 1'b1;
            err_reg       <= 1'b1;
            err_cause_reg <= ERR_TMO;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            load_data_reg <= 32'h0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
          err_reg   <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign stall         = (state_reg == ST_IDLE && cpu_req) || (state_reg == ST_BUSY);
  assign done          = done_reg;
  assign err           = err_reg;
  assign err_cause     = err_cause_reg;
  assign load_data     = load_data_reg;
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_be    = mem_be_reg;
  assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, random accesses checked
// against a size/offset arithmetic model, plus reset and stray-ack sequences.
module tb_lsu_mem_master;

  localparam int TMO = 4;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;       // BUSY cycles before ack; negative = never
    bit          exp_err;
    logic [1:0]  exp_cause;
    int          exp_done;  // cycle of the done pulse, request at cycle 0
    int          exp_req;   // cycles with mem_req high
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        stall, done, err;
  logic [31:0] load_data;
  logic [1:0]  err_cause;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_if #(.ADDR_W(32)) mem_bus ();

  lsu_mem_master #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_funct3 (cpu_funct3),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .err        (err),
    .err_cause  (err_cause),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // Reference: derive everything from access size and byte offset.
  function automatic vec_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
    vec_t v;
    int size, off;
    bit ill, mis;
    logic [31:0] sh;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
    v.exp_err = 0; v.exp_cause = 0; v.exp_be = 0; v.exp_wdata = 0; v.exp_load = 0;
    off  = int'(addr % 4);
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    ill  = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4);
    mis  = (off % size) != 0;
    if (ill || mis) begin
      v.exp_err = 1; v.exp_cause = ill ? 2'b10 : 2'b01; v.exp_done = 1; v.exp_req = 0;
    end else begin
      v.exp_be    = we ? 4'(((1 << size) - 1) << off) : 4'hF;
      v.exp_wdata = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
      if (dly >= 0 && dly < TMO) begin
        v.exp_done = dly + 2; v.exp_req = dly + 1;
        sh = rdata >> (8 * off);
        if (we)             v.exp_load = 0;
        else if (size == 1) v.exp_load = (f3 < 4) ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        else if (size == 2) v.exp_load = (f3 < 4) ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        else                v.exp_load = rdata;
      end else begin
        v.exp_err = 1; v.exp_cause = 2'b11; v.exp_done = TMO + 1; v.exp_req = TMO;
      end
    end
    return v;
  endfunction

  // Called just after a negedge with the DUT idle; that cycle is cycle 0.
  task automatic run_vec(input vec_t v, input int idx);
    int done_cyc = -1, req_cnt = 0, stall_cnt = 0;
    bit unstable = 0, got_err = 0, got_we = 0, after_done = 0;
    logic [1:0]  got_cause = 0;
    logic [31:0] got_load = 0, a_addr = 0, a_wdata = 0;
    logic [3:0]  a_be = 0;
    cpu_req = 1; cpu_we = v.we; cpu_funct3 = v.f3; cpu_addr = v.addr; cpu_wdata = v.wdata;
    mem_bus.mem_rdata = v.rdata; mem_bus.mem_ack = 0;
    for (int cyc = 0; cyc < 20 && done_cyc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (stall) stall_cnt++;
      if (mem_bus.mem_req) begin
        if (req_cnt == 0) begin
          a_addr = mem_bus.mem_addr; a_be = mem_bus.mem_be;
          a_wdata = mem_bus.mem_wdata; got_we = mem_bus.mem_we;
        end else if (a_addr !== mem_bus.mem_addr || a_be !== mem_bus.mem_be ||
                     a_wdata !== mem_bus.mem_wdata || got_we !== mem_bus.mem_we) begin
          unstable = 1;
        end
        req_cnt++;
        mem_bus.mem_ack = (v.dly >= 0 && req_cnt - 1 == v.dly);
      end else begin
        mem_bus.mem_ack = 0;
      end
      if (done) begin
        done_cyc = cyc; got_err = err; got_cause = err_cause; got_load = load_data;
        cpu_req = 0;
      end
    end
    cpu_req = 0; mem_bus.mem_ack = 0;
    @(negedge clk); #1;
    after_done = done;

    $display("[TB] vec %0d we=%0d f3=%0d addr=%h dly=%0d -> done@%0d req=%0d err=%0d cause=%0d load=%h",
             idx, v.we, v.f3, v.addr, v.dly, done_cyc, req_cnt, got_err, got_cause, got_load);
    chk("done_cycle", idx, done_cyc, v.exp_done);
    chk("req_cycles", idx, req_cnt, v.exp_req);
    chk("stall_cycles", idx, stall_cnt, v.exp_done);
    chk("err", idx, got_err, v.exp_err);
    chk("done_pulse_width", idx, after_done, 0);
    if (v.exp_err) chk("err_cause", idx, got_cause, v.exp_cause);
    else           chk("load_data", idx, got_load, v.exp_load);
    if (v.exp_req > 0) begin
      chk("mem_addr", idx, a_addr, v.addr & 32'hFFFF_FFFC);
      chk("mem_we", idx, got_we, v.we);
      chk("mem_be", idx, a_be, v.exp_be);
      chk("fields_stable", idx, unstable, 0);
      if (v.we) chk("mem_wdata", idx, a_wdata, v.exp_wdata);
    end
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 2'b00, 2, 1, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 2'b00, 2, 1, 4'h8, 32'hA5A5A5A5, 32'h0};
    tbl[2]  = '{0, 3'b000, 32'h103, 32'h0,        32'hA5000000, 0, 0, 2'b00, 2, 1, 4'hF, 32'h0, 32'hFFFFFFA5};
    tbl[3]  = '{0, 3'b100, 32'h103, 32'h0,        32'hA5000000, 1, 0, 2'b00, 3, 2, 4'hF, 32'h0, 32'h000000A5};
    tbl[4]  = '{0, 3'b001, 32'h102, 32'h0,        32'h80010000, 3, 0, 2'b00, 5, 4, 4'hF, 32'h0, 32'hFFFF8001};
    tbl[5]  = '{0, 3'b101, 32'h102, 32'h0,        32'h80010000, 2, 0, 2'b00, 4, 3, 4'hF, 32'h0, 32'h00008001};
    tbl[6]  = '{0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1, 2'b01, 1, 0, 4'h0, 32'h0, 32'h0};
    tbl[7]  = '{0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 2'b10, 1, 0, 4'h0, 32'h0, 32'h0};
    tbl[8]  = '{1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1, 2'b10, 1, 0, 4'h0, 32'h0, 32'h0};
    tbl[9]  = '{1, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1, 2'b01, 1, 0, 4'h0, 32'h0, 32'h0};
    tbl[10] = '{0, 3'b011, 32'h101, 32'h0,        32'h0,        0, 1, 2'b10, 1, 0, 4'h0, 32'h0, 32'h0};
    tbl[11] = '{1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,        0, 0, 2'b00, 2, 1, 4'hC, 32'hBEEFBEEF, 32'h0};
    tbl[12] = '{0, 3'b010, 32'h108, 32'h0,        32'h12345678, 0, 0, 2'b00, 2, 1, 4'hF, 32'h0, 32'h12345678};
    tbl[13] = '{0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 2, 0, 2'b00, 4, 3, 4'hF, 32'h0, 32'h0000007F};
    tbl[14] = '{1, 3'b000, 32'h101, 32'hFFFFFF3C, 32'h0,        1, 0, 2'b00, 3, 2, 4'h2, 32'h3C3C3C3C, 32'h0};
    tbl[15] = '{0, 3'b010, 32'h200, 32'h0,        32'h0,       -1, 1, 2'b11, 5, 4, 4'hF, 32'h0, 32'h0};

    rst = 1; cpu_req = 0; cpu_we = 0; cpu_funct3 = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", -1, stall, 0);
    chk("rst_done", -1, done, 0);
    chk("rst_err", -1, {err, err_cause}, 0);
    chk("rst_load_data", -1, load_data, 0);
    chk("rst_mem_req_we", -1, {mem_bus.mem_req, mem_bus.mem_we}, 0);
    chk("rst_mem_addr", -1, mem_bus.mem_addr, 0);
    chk("rst_mem_be", -1, mem_bus.mem_be, 0);
    chk("rst_mem_wdata", -1, mem_bus.mem_wdata, 0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

    // Stray acks while idle must not start or finish anything.
    mem_bus.mem_ack = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("stray_ack_mem_req", 100, mem_bus.mem_req, 0);
      chk("stray_ack_done", 100, done, 0);
      chk("stray_ack_stall", 100, stall, 0);
    end
    mem_bus.mem_ack = 0;
    @(negedge clk);

    // Reset in the second BUSY cycle aborts the access without a done pulse.
    cpu_req = 1; cpu_we = 0; cpu_funct3 = 3'b010; cpu_addr = 32'h300;
    @(negedge clk); #1;
    chk("rst_seq_busy_req", 101, mem_bus.mem_req, 1);
    @(negedge clk); #1;
    rst = 1; cpu_req = 0;
    @(negedge clk); #1;
    chk("rst_seq_mem_req", 101, mem_bus.mem_req, 0);
    chk("rst_seq_stall", 101, stall, 0);
    chk("rst_seq_done", 101, done, 0);
    rst = 0;
    @(negedge clk); #1;
    chk("rst_seq_no_done", 101, done, 0);
    run_vec(model(1'b0, 3'b001, 32'h00000306, 32'h0, 32'h7FFE1234, 1), 102);

    for (int i = 0; i < 150; i++) begin
      bit          r_we;
      logic [2:0]  r_f3;
      int          r_dly;
      r_we  = 1'($urandom_range(0, 1));
      r_f3  = 3'($urandom_range(0, 7));
      r_dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      run_vec(model(r_we, r_f3, $urandom, $urandom, $urandom, r_dly), 1000 + i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- CPU-side load/store initiator that drives the data-memory responder.
- Accepts one load or store per request from the core's MEM stage and checks alignment and size.
- Steers bytes into word-aligned memory accesses with per-byte write enables.
- Waits for a memory acknowledge, then returns the sign- or zero-extended load data with a one-cycle done pulse. It stalls the core while an access is in flight.

Parameters:
- TIMEOUT_CYCLES, 0, cycles in BUSY without mem_ack before a bus error is reported; 0 disables the timeout.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  access request; held by the core while stall=1
- cpu_we  in  1  1=store, 0=load
- cpu_funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data; low bits are used for B/H
- stall  out  1  holds the core pipeline
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid while done=1
- err  out  1  access failed; pulses together with done
- err_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
- mem_req  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address, {cpu_addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  responder completes the access this cycle; read data is valid
- mem_rdata  in  32  read word

Behaviour:
- States: IDLE, BUSY, RESP. Reset: state=IDLE, and all outputs are 0 (mem_addr, mem_wdata, mem_be, load_data, err_cause included).
- stall = (state==IDLE & cpu_req) | (state==BUSY). It is low in RESP.
- IDLE with cpu_req=1:
  - Latch we, funct3, addr[1:0], mem_addr, mem_be and mem_wdata.
  - If the access is legal, go to BUSY.
  - If not, go to RESP with err=1 and the matching err_cause. No memory access is made.
- Illegal funct3: 011, 110, 111, and 100/101 when cpu_we=1. Illegal funct3 takes priority over misalignment.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- BUSY:
  - mem_req=1 and mem_we=latched we. mem_addr, mem_be and mem_wdata stay stable until ack.
  - On mem_ack: capture the extended load data (stores give 0), then go to RESP.
  - The timeout counter resets on entry to BUSY. When it reaches TIMEOUT_CYCLES (if nonzero) without ack, go to RESP with err=1 and cause 11.
- RESP: done=1 for one cycle, then IDLE. A cpu_req seen in RESP is not accepted; it is re-evaluated in IDLE on the following cycle.
- Minimum latency with a zero-wait responder:
  - request seen in IDLE at cycle 0
  - mem_req=1 at cycle 1, ack at cycle 1
  - done=1 at cycle 2
- Store steering:
  - SB: be=4'b0001<<addr[1:0], wdata={4{b}}
  - SH: be = addr[1] ? 1100 : 0011, wdata={2{h}}
  - SW: be=1111
- Loads: mem_be=1111 and mem_we=0. The byte or half is selected by the latched addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- mem_ack outside BUSY is ignored.
- rst during BUSY: mem_req drops at the next edge, and no done pulse is produced for the aborted access.
- done and load_data are registered. load_data holds its value until the next RESP.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding
  - err_cause codes ERR_MISAL, ERR_ILL, ERR_TMO
- Sub-module lsu_align: purely combinational.
  - Store path: funct3 + addr[1:0] + wdata -> be, lane data.
  - Load path: funct3 + addr[1:0] + rdata -> extended data.
  - Legality flags.
- FSM and timeout counter stay in lsu_mem_master.

Test Plan:
- SW addr=0x104 wdata=0xDEADBEEF, ack in the first BUSY cycle -> mem_addr=0x104, be=1111, mem_wdata=0xDEADBEEF, mem_we=1, done at cycle 2, stall high for cycles 0-1.
- SB addr=0x103 wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5. Then LB addr=0x103 with rdata=0xA5000000 -> load_data=0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr=0x102, rdata=0x80010000, ack delayed 3 cycles -> mem_req high for 4 cycles with fields stable, load_data=0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x101 -> no mem_req, done=1, err=1, err_cause=01 at cycle 1. funct3=011 -> err_cause=10.
- TIMEOUT_CYCLES=4, mem_ack never asserted -> err=1, err_cause=11, done after 4 BUSY cycles. A later stray mem_ack in IDLE has no effect.
- rst asserted in the second BUSY cycle -> next cycle mem_req=0, stall=0, done=0, state IDLE. A new request then completes normally.
